// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipe: load-use, hi/lo divider
// occupancy, M-stage exception abort, and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Drs,
  input  logic [4:0]       Drt,
  input  logic             Drs_used,
  input  logic             Drt_used,
  input  logic             Dhilo_use,
  input  logic [4:0]       Ern,
  input  logic             Ew_rf,
  input  logic             Eload,
  input  logic             Ediv_start,
  input  logic             Mexc,
  output logic             Fwena,
  output logic             Dwena,
  output logic             FDflush,
  output logic             DEflush,
  output logic             EMflush,
  output logic             div_busy,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [5:0]       LAT  = 6'(DIV_LAT);
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SATV = {CNT_W{1'b1}};

  logic [5:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic lu, hilo;
  logic act_exc, act_hilo, act_lu;

  assign div_busy = (cnt_q != 6'd0);
  assign div_done = (cnt_q == 6'd1);

  assign lu = Eload & Ew_rf & (Ern != 5'd0) &
              ((Drs_used & (Drs == Ern)) |
               (Drt_used & (Drt == Ern)));

  // a start in E also blocks D: it would enter E mid-divide
  assign hilo = Dhilo_use & (div_busy | Ediv_start);

  assign act_exc  = Mexc;
  assign act_hilo = ~Mexc & hilo;
  assign act_lu   = ~Mexc & ~hilo & lu;

  always_comb begin
    Fwena   = 1'b1;
    Dwena   = 1'b1;
    FDflush = 1'b0;
    DEflush = 1'b0;
    EMflush = 1'b0;
    unique case (1'b1)
      act_exc: begin
        FDflush = 1'b1;
        DEflush = 1'b1;
        EMflush = 1'b1;
      end
      act_hilo, act_lu: begin
        Fwena   = 1'b0;
        Dwena   = 1'b0;
        DEflush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (Mexc)
      cnt_d = 6'd0;
    else if (Ediv_start)
      cnt_d = LAT;
    else if (cnt_q != 6'd0)
      cnt_d = cnt_q - 6'd1;
  end

  always_comb begin
    stall_d = stall_q;
    if (!Fwena && stall_q != SATV)
      stall_d = stall_q + ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 6'd0;
      stall_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table vectors through a scoreboard queue,
// plus reset-mid-divide and counter saturation sequences.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    Drs, Drt, Ern;
  logic          Drs_used, Drt_used, Dhilo_use;
  logic          Ew_rf, Eload, Ediv_start, Mexc;
  logic          Fwena, Dwena, FDflush, DEflush, EMflush;
  logic          div_busy, div_done;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_LAT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Drs(Drs), .Drt(Drt),
    .Drs_used(Drs_used), .Drt_used(Drt_used),
    .Dhilo_use(Dhilo_use),
    .Ern(Ern), .Ew_rf(Ew_rf), .Eload(Eload),
    .Ediv_start(Ediv_start), .Mexc(Mexc),
    .Fwena(Fwena), .Dwena(Dwena),
    .FDflush(FDflush), .DEflush(DEflush),
    .EMflush(EMflush),
    .div_busy(div_busy), .div_done(div_done),
    .stall_cycles(stall_cycles)
  );

  // {Fwena,Dwena,FDflush,DEflush,EMflush,div_busy,div_done}
  localparam logic [6:0] RUN    = 7'b1100000;
  localparam logic [6:0] RUN_B  = 7'b1100010;
  localparam logic [6:0] RUN_BD = 7'b1100011;
  localparam logic [6:0] STL    = 7'b0001000;
  localparam logic [6:0] STL_B  = 7'b0001010;
  localparam logic [6:0] STL_BD = 7'b0001011;
  localparam logic [6:0] EXC    = 7'b1111100;
  localparam logic [6:0] EXC_B  = 7'b1111110;

  typedef struct {
    string      nm;
    logic [4:0] drs, drt, ern;
    logic       rsu, rtu, hl;
    logic       ew, ld, ds, mx;
    logic [6:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [6:0]  sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [CW-1:0] stall_m;

  function automatic vec_t V(string nm,
    logic [4:0] drs, logic [4:0] drt,
    logic rsu, logic rtu, logic hl,
    logic [4:0] ern, logic ew, logic ld,
    logic ds, logic mx, logic [6:0] exp);
    vec_t v;
    v.nm = nm; v.drs = drs; v.drt = drt;
    v.rsu = rsu; v.rtu = rtu; v.hl = hl;
    v.ern = ern; v.ew = ew; v.ld = ld;
    v.ds = ds; v.mx = mx; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t IDLE(string nm, logic [6:0] exp);
    return V(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp);
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic drive(vec_t v);
    Drs = v.drs; Drt = v.drt;
    Drs_used = v.rsu; Drt_used = v.rtu;
    Dhilo_use = v.hl; Ern = v.ern;
    Ew_rf = v.ew; Eload = v.ld;
    Ediv_start = v.ds; Mexc = v.mx;
  endtask

  function automatic logic [6:0] outs();
    return {Fwena, Dwena, FDflush, DEflush,
            EMflush, div_busy, div_done};
  endfunction

  // drive at posedge+1, compare at negedge, advance stall model
  task automatic run_vec(vec_t v);
    logic [6:0] e;
    drive(v);
    sb.push_back(v.exp);
    @(negedge clk);
    e = sb.pop_front();
    chk({v.nm, "/outs"}, 32'(outs()), 32'(e));
    chk({v.nm, "/stall"}, 32'(stall_cycles), 32'(stall_m));
    @(posedge clk);
    #1;
    if (!e[6] && stall_m != {CW{1'b1}})
      stall_m = stall_m + 1'b1;
  endtask

  initial begin
    stall_m = '0;
    rst = 1'b0;
    drive(IDLE("x", RUN));

    // lu, ern=0, each use-enable gated
    tbl.push_back(IDLE("idle0", RUN));
    tbl.push_back(V("lu_rt", 0, 5, 0, 1, 0, 5, 1, 1, 0, 0, STL));
    tbl.push_back(IDLE("after_lu", RUN));
    tbl.push_back(V("lu_r0", 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, RUN));
    tbl.push_back(V("lu_rs", 7, 7, 1, 0, 0, 7, 1, 1, 0, 0, STL));
    tbl.push_back(V("rs_unused", 7, 3, 0, 1, 0, 7, 1, 1, 0, 0, RUN));
    tbl.push_back(V("no_wrf", 7, 7, 1, 1, 0, 7, 0, 1, 0, 0, RUN));
    tbl.push_back(V("no_load", 7, 7, 1, 1, 0, 7, 1, 0, 0, 0, RUN));
    // divide + stalled hilo reader
    tbl.push_back(V("div_c0", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, STL));
    tbl.push_back(V("div_c1", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL_B));
    tbl.push_back(V("div_c2", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL_B));
    tbl.push_back(V("div_c3", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL_B));
    tbl.push_back(V("div_c4", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL_BD));
    tbl.push_back(V("div_c5", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, RUN));
    // exception aborts divide at cnt=3
    tbl.push_back(V("abt_st", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUN));
    tbl.push_back(IDLE("abt_c4", RUN_B));
    tbl.push_back(V("abt_exc", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, EXC_B));
    tbl.push_back(IDLE("abt_n1", RUN));
    tbl.push_back(IDLE("abt_n2", RUN));
    // exception wins over hilo and lu; start ignored
    tbl.push_back(V("all3", 0, 9, 0, 1, 1, 9, 1, 1, 1, 1, EXC));
    tbl.push_back(IDLE("all3_n", RUN));
    // back-to-back start at cnt=1
    tbl.push_back(V("b2b_st", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUN));
    tbl.push_back(IDLE("b2b_4", RUN_B));
    tbl.push_back(IDLE("b2b_3", RUN_B));
    tbl.push_back(IDLE("b2b_2", RUN_B));
    tbl.push_back(V("b2b_re", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUN_BD));
    tbl.push_back(IDLE("b2b_r4", RUN_B));
    tbl.push_back(IDLE("b2b_r3", RUN_B));
    tbl.push_back(IDLE("b2b_r2", RUN_B));
    tbl.push_back(IDLE("b2b_r1", RUN_BD));
    tbl.push_back(IDLE("b2b_end", RUN));

    // reset state
    #7;
    chk("rst/outs", 32'(outs()), 32'(RUN));
    chk("rst/stall", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);
    chk("stall_total", 32'(stall_cycles), 32'd7);

    // reset in the middle of a divide
    run_vec(V("mr_st", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUN));
    run_vec(IDLE("mr_b", RUN_B));
    rst = 1'b0;
    #1;
    chk("mr/busy", 32'(div_busy), 32'd0);
    chk("mr/stall", 32'(stall_cycles), 32'd0);
    stall_m = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 5; k++)
      run_vec(IDLE("mr_after", RUN));

    // saturate the 4-bit counter with repeated stalls
    for (int k = 0; k < 17; k++)
      run_vec(V("sat_lu", 3, 0, 1, 0, 0, 3, 1, 1, 0, 0, STL));
    run_vec(IDLE("sat_hold", RUN));
    chk("sat_final", 32'(stall_cycles), 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
